// File: rtl/regfile_access_arbiter_if.sv
// Word-level request bundle between one requester and the register-file arbiter.
interface regfile_access_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/regfile_access_arbiter.sv
// Two-requester arbiter that splits 16-bit word requests into low/high byte
// accesses on the single 8-bit register-file port.
module regfile_access_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  regfile_access_arbiter_if.slave        r0_if,
  regfile_access_arbiter_if.slave        r1_if,
  output logic [3:0]                     rf_addr_o,
  output logic                           rf_high_b_o,
  output logic [7:0]                     rf_d_in_o,
  output logic                           rf_write_en_o,
  input  logic [7:0]                     rf_q_out_i,
  output logic                           busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] addr;
    logic       high_b;
    logic [7:0] d_in;
    logic       write_en;
  } rf_bus_t;

  // Data lines stay quiet on read cycles so the file only sees write data when writing.
  function automatic rf_bus_t rf_drive(input logic hi, input logic we,
                                       input logic [3:0] addr, input logic [7:0] data);
    rf_bus_t b;
    b.addr     = addr;
    b.high_b   = hi;
    b.d_in     = we ? data : 8'h00;
    b.write_en = we;
    return b;
  endfunction

  state_e      state_q;
  rf_bus_t     rf_q;
  logic        gnt_q;
  logic        rr_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [3:0]  addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  cap_lo_q;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        busy_q;

  logic        gnt_s;
  logic        sel_we_s;
  logic [1:0]  sel_be_s;
  logic [3:0]  sel_addr_s;
  logic [15:0] sel_wdata_s;

  // rr_q set means r1 wins the next tie; fixed priority ignores it.
  assign gnt_s       = r1_if.req & (~r0_if.req | (~FIXED_PRIO & rr_q));
  assign sel_we_s    = gnt_s ? r1_if.we    : r0_if.we;
  assign sel_be_s    = gnt_s ? r1_if.be    : r0_if.be;
  assign sel_addr_s  = gnt_s ? r1_if.addr  : r0_if.addr;
  assign sel_wdata_s = gnt_s ? r1_if.wdata : r0_if.wdata;

  // Sequencer: all outputs are registered and set on entry to the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rf_q     <= '0;
      gnt_q    <= 1'b0;
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      addr_q   <= 4'h0;
      wdata_q  <= 16'h0000;
      cap_lo_q <= 8'h00;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rf_q   <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (r0_if.req | r1_if.req) begin
            gnt_q   <= gnt_s;
            rr_q    <= ~gnt_s;
            we_q    <= sel_we_s;
            be_q    <= sel_be_s;
            addr_q  <= sel_addr_s;
            wdata_q <= sel_wdata_s;
            busy_q  <= 1'b1;
            if (!sel_we_s || sel_be_s[0]) begin
              state_q <= ST_LO;
              rf_q    <= rf_drive(1'b0, sel_we_s, sel_addr_s, sel_wdata_s[7:0]);
            end else if (sel_be_s[1]) begin
              state_q <= ST_HI;
              rf_q    <= rf_drive(1'b1, 1'b1, sel_addr_s, sel_wdata_s[15:8]);
            end else begin
              state_q <= ST_ACK;
              ack0_q  <= ~gnt_s;
              ack1_q  <= gnt_s;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LO: begin
          if (!we_q) begin
            cap_lo_q <= rf_q_out_i;
          end
          if (!we_q || be_q[1]) begin
            state_q <= ST_HI;
            rf_q    <= rf_drive(1'b1, we_q, addr_q, wdata_q[15:8]);
          end else begin
            state_q <= ST_ACK;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
          end
        end
        ST_HI: begin
          state_q <= ST_ACK;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          if (!we_q) begin
            if (gnt_q) begin
              rdata1_q <= {rf_q_out_i, cap_lo_q};
            end else begin
              rdata0_q <= {rf_q_out_i, cap_lo_q};
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rf_addr_o     = rf_q.addr;
  assign rf_high_b_o   = rf_q.high_b;
  assign rf_d_in_o     = rf_q.d_in;
  assign rf_write_en_o = rf_q.write_en;
  assign busy_o        = busy_q;
  assign r0_if.ack     = ack0_q;
  assign r1_if.ack     = ack1_q;
  assign r0_if.rdata   = rdata0_q;
  assign r1_if.rdata   = rdata1_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench: round-robin arbiter against a byte-ported file model, plus a
// fixed-priority instance used only for the starvation check.
module tb_regfile_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  regfile_access_arbiter_if r0_if ();
  regfile_access_arbiter_if r1_if ();
  regfile_access_arbiter_if f0_if ();
  regfile_access_arbiter_if f1_if ();

  logic [3:0] rf_addr_s;
  logic       rf_high_b_s;
  logic [7:0] rf_d_in_s;
  logic       rf_we_s;
  logic [7:0] rf_q_out_s;
  logic       busy_s;
  logic [3:0] f_addr_s;
  logic       f_high_b_s;
  logic [7:0] f_d_in_s;
  logic       f_we_s;
  logic       f_busy_s;

  regfile_access_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .r0_if(r0_if), .r1_if(r1_if),
    .rf_addr_o(rf_addr_s), .rf_high_b_o(rf_high_b_s), .rf_d_in_o(rf_d_in_s),
    .rf_write_en_o(rf_we_s), .rf_q_out_i(rf_q_out_s), .busy_o(busy_s)
  );

  regfile_access_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .r0_if(f0_if), .r1_if(f1_if),
    .rf_addr_o(f_addr_s), .rf_high_b_o(f_high_b_s), .rf_d_in_o(f_d_in_s),
    .rf_write_en_o(f_we_s), .rf_q_out_i(8'h00), .busy_o(f_busy_s)
  );

  // 16x16 byte-ported register file with combinational read.
  logic [15:0] mem [16];
  assign rf_q_out_s = rf_high_b_s ? mem[rf_addr_s][15:8] : mem[rf_addr_s][7:0];
  always @(posedge clk) begin
    if (rf_we_s) begin
      if (rf_high_b_s) mem[rf_addr_s][15:8] <= rf_d_in_s;
      else             mem[rf_addr_s][7:0]  <= rf_d_in_s;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int who, input logic req, input logic we, input logic [1:0] be,
                         input logic [3:0] addr, input logic [15:0] wdata);
    case (who)
      0: begin r0_if.req = req; r0_if.we = we; r0_if.be = be; r0_if.addr = addr; r0_if.wdata = wdata; end
      1: begin r1_if.req = req; r1_if.we = we; r1_if.be = be; r1_if.addr = addr; r1_if.wdata = wdata; end
      2: begin f0_if.req = req; f0_if.we = we; f0_if.be = be; f0_if.addr = addr; f0_if.wdata = wdata; end
      default: begin f1_if.req = req; f1_if.we = we; f1_if.be = be; f1_if.addr = addr; f1_if.wdata = wdata; end
    endcase
  endtask

  // Issue one request on the round-robin DUT; lat counts negedges from request to ack.
  task automatic do_req(input int who, input logic we, input logic [1:0] be,
                        input logic [3:0] addr, input logic [15:0] wdata,
                        output int lat, output logic [15:0] rdata, output int wcnt,
                        output logic [8:0] wlog0, output logic [8:0] wlog1);
    lat = -1; wcnt = 0; wlog0 = 9'h000; wlog1 = 9'h000; rdata = 16'h0000;
    @(negedge clk);
    set_req(who, 1'b1, we, be, addr, wdata);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rf_we_s) begin
        if (wcnt == 0) wlog0 = {rf_high_b_s, rf_d_in_s};
        else           wlog1 = {rf_high_b_s, rf_d_in_s};
        wcnt++;
      end
      if ((who == 0 && r0_if.ack) || (who == 1 && r1_if.ack)) begin
        lat   = n;
        rdata = (who == 0) ? r0_if.rdata : r1_if.rdata;
        break;
      end
    end
    set_req(who, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
  endtask

  int          lat, wc, a0_at, a1_at, k, na0, na1, bad;
  logic [15:0] rd, r1rd;
  logic [8:0]  w0, w1;
  logic [3:0]  order;

  initial begin
    rst_n = 1'b0;
    for (int w = 0; w < 4; w++) set_req(w, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {busy_s, rf_we_s, rf_d_in_s, rf_addr_s, rf_high_b_s, r0_if.ack, r1_if.ack}, 32'h0);
    check_eq("rst_rdata", {r0_if.rdata, r1_if.rdata}, 32'h0);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ({busy_s, rf_we_s, r0_if.ack, r1_if.ack, f_busy_s} != 5'b00000) bad++;
    end
    check_eq("idle_quiet_20", bad, 0);

    do_req(0, 1'b1, 2'b11, 4'h3, 16'hA55A, lat, rd, wc, w0, w1);
    check_eq("wr11_lat", lat, 3);
    check_eq("wr11_nbytes", wc, 2);
    check_eq("wr11_lo_byte", w0, 9'h05A);
    check_eq("wr11_hi_byte", w1, 9'h1A5);
    check_eq("wr11_mem", mem[3], 16'hA55A);

    do_req(0, 1'b0, 2'b00, 4'h3, 16'h0000, lat, rd, wc, w0, w1);
    check_eq("rd3_lat", lat, 3);
    check_eq("rd3_data", rd, 16'hA55A);
    check_eq("rd3_no_write", wc, 0);
    check_eq("r1_rdata_untouched", r1_if.rdata, 16'h0000);

    do_req(0, 1'b1, 2'b11, 4'h5, 16'hFFFF, lat, rd, wc, w0, w1);
    check_eq("wr_ffff_lat", lat, 3);
    do_req(0, 1'b1, 2'b10, 4'h5, 16'h1234, lat, rd, wc, w0, w1);
    check_eq("wr10_lat", lat, 2);
    check_eq("wr10_nbytes", wc, 1);
    check_eq("wr10_hi_byte", w0, 9'h112);
    do_req(0, 1'b0, 2'b00, 4'h5, 16'h0000, lat, rd, wc, w0, w1);
    check_eq("rd5_after_be10", rd, 16'h12FF);
    do_req(0, 1'b1, 2'b00, 4'h5, 16'h0000, lat, rd, wc, w0, w1);
    check_eq("wr00_lat", lat, 1);
    check_eq("wr00_nbytes", wc, 0);
    check_eq("wr00_rdata_held", r0_if.rdata, 16'h12FF);
    do_req(0, 1'b0, 2'b00, 4'h5, 16'h0000, lat, rd, wc, w0, w1);
    check_eq("rd5_after_be00", rd, 16'h12FF);

    // A lone r1 grant leaves the round-robin pointer favouring r0.
    do_req(1, 1'b1, 2'b11, 4'hF, 16'h0000, lat, rd, wc, w0, w1);
    check_eq("r1_wr_lat", lat, 3);

    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b11, 4'hF, 16'hBEEF);
    set_req(1, 1'b1, 1'b0, 2'b00, 4'hF, 16'h0000);
    a0_at = -1; a1_at = -1; r1rd = 16'h0000;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (r0_if.ack) begin a0_at = n; set_req(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000); end
      if (r1_if.ack) begin a1_at = n; r1rd = r1_if.rdata; break; end
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    set_req(1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    check_eq("raw_r0_ack_at", a0_at, 3);
    check_eq("raw_r1_ack_at", a1_at, 7);
    check_eq("raw_r1_data", r1rd, 16'hBEEF);

    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'b00, 4'h3, 16'h0000);
    set_req(1, 1'b1, 1'b0, 2'b00, 4'h5, 16'h0000);
    k = 0; order = 4'h0;
    for (int n = 1; n <= 40 && k < 4; n++) begin
      @(negedge clk);
      if (r0_if.ack) begin order[k] = 1'b0; k++; end
      else if (r1_if.ack) begin order[k] = 1'b1; k++; end
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    set_req(1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    check_eq("rr_ack_count", k, 4);
    check_eq("rr_order", order, 4'b1010);
    check_eq("rr_r1_rdata", r1_if.rdata, 16'h12FF);

    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 2'b00, 4'h1, 16'h0000);
    set_req(3, 1'b1, 1'b0, 2'b00, 4'h2, 16'h0000);
    na0 = 0; na1 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (f0_if.ack) na0++;
      if (f1_if.ack) na1++;
    end
    check_eq("fp_r0_acks", na0, 5);
    check_eq("fp_r1_starved", na1, 0);
    set_req(2, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (f1_if.ack) begin lat = n; break; end
    end
    set_req(3, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    check_eq("fp_r1_after_release", lat, 3);

    // Reset during the HI cycle of a write: low byte already landed, high byte never does.
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b11, 4'h3, 16'h6789);
    @(negedge clk);
    check_eq("mid_lo_phase", {rf_we_s, rf_high_b_s, rf_d_in_s}, 10'h289);
    @(negedge clk);
    check_eq("mid_hi_phase", {rf_we_s, rf_high_b_s, rf_d_in_s}, 10'h367);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_async", {busy_s, rf_we_s, rf_high_b_s, rf_d_in_s, rf_addr_s, r0_if.ack}, 32'h0);
    set_req(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if ({busy_s, r0_if.ack, rf_we_s} != 3'b000) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_mem", mem[3], 16'hA589);
    do_req(0, 1'b0, 2'b00, 4'h3, 16'h0000, lat, rd, wc, w0, w1);
    check_eq("post_rst_rd_lat", lat, 3);
    check_eq("post_rst_rd_data", rd, 16'hA589);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
